// File: rtl/arb_join2.sv
// Two-master to one-slave join: round-robin arbiter with a grant lock held across
// a stalled handshake, plus an ID FIFO that routes in-order read responses back.
module arb_join2 #(
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_resp,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_resp,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_resp,
    input  logic [31:0] s_rdata
);

    localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {GRANT_NONE, GRANT_M0, GRANT_M1} grant_t;

    grant_t             grant;
    logic               locked;
    logic               lock_id;
    logic               prio;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               id_mem [RESP_FIFO_DEPTH];
    logic               full;
    logic               elig0;
    logic               elig1;
    logic               handshake;
    logic               push;
    logic               pop;
    logic               head_id;

    // Full is judged on the registered count, so a pop cannot unblock a read in its own cycle.
    assign full  = (count == CNT_W'(RESP_FIFO_DEPTH));
    assign elig0 = m0_req && (m0_we || !full);
    assign elig1 = m1_req && (m1_we || !full);

    always_comb begin
        // NOTE: default assignment first keeps this process free of inferred latches.
        grant = GRANT_NONE;
        if (rst_i) begin
            grant = GRANT_NONE;
        end else if (locked) begin
            grant = lock_id ? GRANT_M1 : GRANT_M0;
        end else if (elig0 && elig1) begin
            grant = prio ? GRANT_M1 : GRANT_M0;
        end else if (elig0) begin
            grant = GRANT_M0;
        end else if (elig1) begin
            grant = GRANT_M1;
        end
    end

    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_be    = '0;
        s_wdata = '0;
        case (grant)
            GRANT_M0: begin
                s_req   = m0_req;
                s_we    = m0_we;
                s_addr  = m0_addr;
                s_be    = m0_be;
                s_wdata = m0_wdata;
            end
            GRANT_M1: begin
                s_req   = m1_req;
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_be    = m1_be;
                s_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    assign handshake = s_req && s_ack;
    assign push      = handshake && !s_we;
    assign pop       = s_resp && (count != '0) && !rst_i;
    assign head_id   = id_mem[rd_ptr];

    assign m0_ack   = handshake && (grant == GRANT_M0);
    assign m1_ack   = handshake && (grant == GRANT_M1);
    assign m0_resp  = pop && !head_id;
    assign m1_resp  = pop && head_id;
    assign m0_rdata = m0_resp ? s_rdata : '0;
    assign m1_rdata = m1_resp ? s_rdata : '0;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            locked  <= 1'b0;
            lock_id <= 1'b0;
            prio    <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (handshake) begin
                locked <= 1'b0;
                prio   <= (grant == GRANT_M0);
            end else if (s_req) begin
                locked  <= 1'b1;
                lock_id <= (grant == GRANT_M1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; entries are only read when count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= (grant == GRANT_M1);
    end

endmodule

// File: doc/arb_join2.md
ARB_JOIN2 -- requirements
Module: arb_join2

Interface
REQ-001 The block SHALL have parameter RESP_FIFO_DEPTH, default 4, meaning the max outstanding reads tracked for response routing (power of 2, 2..16).
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 m0_req/m0_we/m0_addr/m0_be/m0_wdata  input  1/1/32/4/32  master 0 command (request, write enable, byte address, byte enables, write data).
REQ-005 m0_ack  output  1  master 0 command accepted this cycle.
REQ-006 m0_resp/m0_rdata  output  1/32  master 0 read response valid, read data.
REQ-007 m1_req/m1_we/m1_addr/m1_be/m1_wdata, m1_ack, m1_resp/m1_rdata  same widths/directions  master 1 equivalents.
REQ-008 s_req/s_we/s_addr/s_be/s_wdata  output  1/1/32/4/32  shared slave command.
REQ-009 s_ack  input  1  slave accepted command.
REQ-010 s_resp/s_rdata  input  1/32  slave read response valid, read data; responses in read-issue order.

Function
REQ-011 Command handshake SHALL complete on a cycle with req=1 and ack=1; a master holds req and command fields stable until ack.
REQ-012 Reads (we=0) SHALL produce exactly one resp pulse; writes (we=1) SHALL produce no resp.
REQ-013 Grant SHALL be one of {M0, M1, none}; s_req/s_we/s_addr/s_be/s_wdata SHALL equal the granted master's fields combinationally; s_req=0 and other s_* fields=0 when no grant.
REQ-014 mX_ack SHALL equal s_ack AND s_req AND (grant==X); non-granted master ack=0.
REQ-015 Arbitration when unlocked: only one master requesting -> that master; both requesting -> master indicated by priority register prio.
REQ-016 prio SHALL update after each completed handshake to the master that did not complete it; prio unchanged otherwise (strict round-robin alternation under continuous contention).
REQ-017 Lock: if s_req=1 and s_ack=0, a lock register SHALL hold the current grant for following cycles until a handshake completes; grant SHALL not switch mid-handshake even if the other master requests.
REQ-018 Response routing FIFO (1-bit master ID, RESP_FIFO_DEPTH entries) SHALL push the granted ID on each read handshake.
REQ-019 On s_resp=1 with FIFO non-empty: mID_resp=1 for head ID, mID_rdata=s_rdata, other master resp=0 and rdata=0; head popped same cycle; zero added latency (combinational route).
REQ-020 Full: when FIFO count==RESP_FIFO_DEPTH, a read request SHALL not be granted (s_req=0 for it, no ack); the other master's write MAY be granted; a pop in the same cycle SHALL NOT unblock that cycle (count is registered).
REQ-021 Simultaneous push and pop: count unchanged, both operations performed, ordering preserved.
REQ-022 s_resp=1 with FIFO empty SHALL be ignored: no mX_resp, count stays 0, no pointer change.
REQ-023 Pointers SHALL wrap modulo RESP_FIFO_DEPTH; count width log2(DEPTH)+1.

Reset
REQ-024 On rst_i=1: FIFO count, read/write pointers=0, lock=0, prio=M0.
REQ-025 During reset all outputs SHALL be 0 (s_req, m0_ack, m1_ack, m0_resp, m1_resp, data fields).
REQ-026 Reset mid-operation SHALL discard outstanding read IDs; slave responses arriving after reset fall under REQ-022.

Verification
REQ-027 Single read: m0 read addr 0x100, s_ack same cycle, s_resp 3 cycles later rdata 0xDEADBEEF -> m0_ack 1 cycle, m0_resp 1 cycle with 0xDEADBEEF, m1_resp=0.
REQ-028 Contention: m0 and m1 hold writes continuously, s_ack=1 always -> acks alternate M0,M1,M0,M1 starting M0 after reset.
REQ-029 Lock: m0 read, s_ack held 0 for 5 cycles, m1 requests on cycle 2 -> s_addr stays m0's for all 6 cycles, m1 granted the cycle after m0_ack.
REQ-030 Full: DEPTH=4, four reads issued with no s_resp -> fifth read blocked (s_req=0); one s_resp -> fifth read granted next cycle.
REQ-031 Ordering: reads m0,m1,m0 issued, responses 0x1,0x2,0x3 -> m0_resp 0x1, m1_resp 0x2, m0_resp 0x3; spurious s_resp with empty FIFO -> no resp.
REQ-032 Reset mid-op: two reads outstanding, rst_i 1 cycle, then s_resp twice -> no mX_resp, count 0.
